mse_batch_collector: RTL and testbench
======================================

# mse_batch_collector

Parametrised multi-candidate error collector for the word-length optimisation hardware loop. It compares NUM_CAND candidate DSP outputs against one full-precision reference output over a fixed batch of samples. It accumulates the squared error per candidate and returns each candidate's mean squared error, one at a time, over a valid/ready handshake to the control unit. It generalises the fixed two-channel per-candidate collectors with configurable candidate count, settle skip, batch length, saturation, input stalls and abort.

## Interface
- NUM_CAND, 4: number of candidate datapaths compared against the reference.
- DATA_WL, 12: word length of candidate and reference samples, signed two's complement.
- ACC_WL, 64: accumulator and result width.
- NUM_SAMPLES, 1024: samples accumulated per batch; power of two, at least 2.
- SKIP, 32: valid samples discarded after start for pipeline settling; 0 is allowed.
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  single-cycle batch start; ignored unless the block is idle.
- abort  in  1  synchronous cancel; returns the block to IDLE.
- in_valid  in  1  data_in and data_ref are valid this cycle.
- data_in  in  NUM_CAND x DATA_WL  candidate samples (unpacked array).
- data_ref  in  DATA_WL  reference sample.
- res_data  out  ACC_WL  MSE of candidate res_idx.
- res_idx  out  $clog2(NUM_CAND) (minimum 1)  candidate index of res_data.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last result is accepted.

## Operation
- States and transitions:
  - IDLE → SETTLE on start. IDLE → ACCUM on start if SKIP=0.
  - SETTLE → ACCUM after SKIP cycles with in_valid high.
  - ACCUM → FLUSH after NUM_SAMPLES cycles with in_valid high.
  - FLUSH → DRAIN once the error pipeline is empty (2 cycles).
  - DRAIN → IDLE after NUM_CAND result handshakes. done pulses on the cycle after the final handshake.
- On entry to SETTLE (or to ACCUM when SKIP=0), all accumulators and the sample counter clear to 0.
- Cycles with in_valid low do not count and do not enter the pipeline in any state.
- Per-candidate error pipeline:
  - Stage 1: diff = data_in[k] − data_ref, DATA_WL+1 bits signed, exact.
  - Stage 2: sq = diff², 2·DATA_WL+2 bits unsigned, exact.
  - Stage 3: acc += sq, zero-extended to ACC_WL. If the sum exceeds 2^ACC_WL−1, acc saturates at 2^ACC_WL−1 and holds there for the rest of the batch.
- Result: res_data = acc[k] >> log2(NUM_SAMPLES), a truncating logical shift. A saturated accumulator yields (2^ACC_WL−1) >> log2(NUM_SAMPLES).
- DRAIN handshake:
  - res_idx starts at 0; res_valid is high.
  - res_data and res_idx stay stable while res_valid=1 and res_ready=0.
  - When res_valid and res_ready are both high, res_idx increments, or the block leaves DRAIN after index NUM_CAND−1.
- abort, in any non-IDLE state: the block goes to IDLE on the next edge. res_valid drops, no done pulse is issued, and accumulators keep stale values that are never presented. abort has priority over start and over handshakes in the same cycle.
- start while busy has no effect.

## Timing
- Reset values: res_data=0, res_idx=0, res_valid=0, busy=0, done=0. State is IDLE and all accumulators and counters are 0.
- start sampled high at edge t → busy=1 from t+1.
- The last counted ACCUM sample is at edge a. The state is FLUSH from a+1 to a+2, and res_valid=1 from a+3.
- Each result needs at least 1 cycle. With res_ready tied high, NUM_CAND consecutive cycles are needed.
- Final handshake at edge h → done=1 and busy=0 from h+1 for exactly one cycle. start is accepted again from h+1.
- Reset asserted mid-operation → all outputs return to reset values immediately (asynchronously).

## Structure
- Package mse_pkg holds the state enum (IDLE, SETTLE, ACCUM, FLUSH, DRAIN) and width helper functions (diff width, square width).
- Sub-module sq_err_acc: one candidate's three-stage diff/square/saturating-accumulate pipeline with clear and valid inputs. It is instantiated NUM_CAND times by a generate loop.
- The top-level FSM owns the counters, the drain index and the result mux.

## Test plan
Unless stated, NUM_CAND=2, DATA_WL=12, ACC_WL=64, NUM_SAMPLES=4, SKIP=2, res_ready=1.
- All candidates equal to the reference → results 0 at res_idx 0 then 1; done pulses once; busy falls with done.
- data_in[0]=ref+3, data_in[1]=ref−5 held constant → results 9 and 25. The first 2 valid samples carry large errors and must be discarded.
- ref=12'h7FF, data_in[0]=12'h800 → diff −4095, result 16769025. With ACC_WL=24, the result is saturated: (2^24−1)>>2 = 4194303.
- in_valid toggles 1,0,0,1,… with the same data as the second scenario → results 9 and 25; the FLUSH-to-res_valid latency is measured from the last valid sample.
- res_ready held low 10 cycles in DRAIN → res_valid, res_data and res_idx remain constant, with no done pulse until both results are accepted.
- abort in the middle of ACCUM, and start pulsed while busy → busy=0 next cycle, no res_valid, no done. A following start runs a clean batch with correct results.

Source files
------------

// File: rtl/mse_batch_collector_pkg.sv
// Shared types and width helpers for the MSE batch collector.
package mse_pkg;

  // Controller states; IDLE must stay at encoding zero so reset reads as idle.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    ACCUM  = 3'd2,
    FLUSH  = 3'd3,
    DRAIN  = 3'd4
  } state_e;

  // Depth of the error pipeline behind the last accepted sample
  // (square stage plus accumulate stage).
  localparam int FLUSH_CYCLES = 2;

  // Exact width of a difference of two dw-bit signed values.
  function automatic int diff_wl(input int dw);
    return dw + 1;
  endfunction

  // Width holding the square of a diff_wl(dw)-bit value without loss.
  function automatic int sq_wl(input int dw);
    return 2 * dw + 2;
  endfunction

endpackage

// File: rtl/mse_batch_collector_sq_err_acc.sv
// One candidate's error path: diff -> square -> saturating accumulate.
module sq_err_acc
  import mse_pkg::*;
#(
  parameter int DATA_WL = 12,
  parameter int ACC_WL  = 64
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               clear,
  input  logic               in_valid,
  input  logic [DATA_WL-1:0] data_in,
  input  logic [DATA_WL-1:0] data_ref,
  output logic [ACC_WL-1:0]  acc
);

  localparam int DIFF_WL = diff_wl(DATA_WL);
  localparam int SQ_WL   = sq_wl(DATA_WL);
  // One spare bit above the wider operand catches any carry past ACC_WL.
  localparam int SUM_WL  = ((ACC_WL > SQ_WL) ? ACC_WL : SQ_WL) + 1;

  logic signed [DIFF_WL-1:0] diff_q, diff_d;
  logic                      v1_q, v1_d;
  logic [SQ_WL-1:0]          sq_q, sq_d;
  logic                      v2_q, v2_d;
  logic [ACC_WL-1:0]         acc_q, acc_d;

  logic signed [SQ_WL-1:0]   diff_ext;
  logic signed [SQ_WL-1:0]   prod;
  logic [SUM_WL-1:0]         sum;

  // Next-state of all three stages; clear wins over everything in flight.
  always_comb begin
    diff_d   = $signed({data_in[DATA_WL-1], data_in}) -
               $signed({data_ref[DATA_WL-1], data_ref});
    v1_d     = in_valid;
    diff_ext = SQ_WL'(diff_q);
    prod     = diff_ext * diff_ext;
    sq_d     = $unsigned(prod);
    v2_d     = v1_q;
    sum      = SUM_WL'(acc_q) + SUM_WL'(sq_q);
    acc_d    = acc_q;
    if (v2_q) begin
      // Once at full scale the sum keeps overflowing, so the value sticks.
      acc_d = (|sum[SUM_WL-1:ACC_WL]) ? '1 : sum[ACC_WL-1:0];
    end
    if (clear) begin
      v1_d  = 1'b0;
      v2_d  = 1'b0;
      acc_d = '0;
    end
  end

  // Pipeline and accumulator registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      diff_q <= '0;
      v1_q   <= 1'b0;
      sq_q   <= '0;
      v2_q   <= 1'b0;
      acc_q  <= '0;
    end else begin
      diff_q <= diff_d;
      v1_q   <= v1_d;
      sq_q   <= sq_d;
      v2_q   <= v2_d;
      acc_q  <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/mse_batch_collector.sv
// Multi-candidate MSE collector: settles, accumulates a batch of squared
// errors per candidate, then hands out one mean per candidate.
//
// Result handshake: a result transfers on a rising edge where res_valid and
// res_ready are both high. While res_valid is high and res_ready is low,
// res_data and res_idx hold. res_valid never drops without a transfer except
// on abort or reset.
module mse_batch_collector
  import mse_pkg::*;
#(
  parameter int NUM_CAND    = 4,
  parameter int DATA_WL     = 12,
  parameter int ACC_WL      = 64,
  parameter int NUM_SAMPLES = 1024,
  parameter int SKIP        = 32
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic               abort,
  input  logic               in_valid,
  input  logic [DATA_WL-1:0] data_in [NUM_CAND],
  input  logic [DATA_WL-1:0] data_ref,
  output logic [ACC_WL-1:0]  res_data,
  output logic [((NUM_CAND > 1) ? $clog2(NUM_CAND) : 1)-1:0] res_idx,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               busy,
  output logic               done,
  output logic [2:0]         dbg_state
);

  localparam int IDX_WL  = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1;
  localparam int LOG2_NS = $clog2(NUM_SAMPLES);
  localparam int CNT_WL  = $clog2(NUM_SAMPLES + SKIP + FLUSH_CYCLES);

  localparam logic [CNT_WL-1:0] SKIP_LAST  = CNT_WL'((SKIP > 0) ? SKIP - 1 : 0);
  localparam logic [CNT_WL-1:0] NS_LAST    = CNT_WL'(NUM_SAMPLES - 1);
  localparam logic [CNT_WL-1:0] FLUSH_LAST = CNT_WL'(FLUSH_CYCLES - 1);
  localparam logic [IDX_WL-1:0] IDX_LAST   = IDX_WL'(NUM_CAND - 1);

  state_e              state_q, state_d;
  logic [CNT_WL-1:0]   cnt_q, cnt_d;
  logic [IDX_WL-1:0]   idx_q, idx_d;
  logic                done_q, done_d;
  logic                clear;
  logic                feed;
  logic [ACC_WL-1:0]   acc_all [NUM_CAND];

  // Next-state, counters and pipeline control; abort overrides all else.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    clear   = 1'b0;
    feed    = 1'b0;
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            clear   = 1'b1;
            cnt_d   = '0;
            idx_d   = '0;
            state_d = (SKIP == 0) ? ACCUM : SETTLE;
          end
        end
        SETTLE: begin
          if (in_valid) begin
            if (cnt_q == SKIP_LAST) begin
              cnt_d   = '0;
              state_d = ACCUM;
            end else begin
              cnt_d = cnt_q + CNT_WL'(1);
            end
          end
        end
        ACCUM: begin
          if (in_valid) begin
            feed = 1'b1;
            if (cnt_q == NS_LAST) begin
              cnt_d   = '0;
              state_d = FLUSH;
            end else begin
              cnt_d = cnt_q + CNT_WL'(1);
            end
          end
        end
        FLUSH: begin
          if (cnt_q == FLUSH_LAST) begin
            cnt_d   = '0;
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + CNT_WL'(1);
          end
        end
        DRAIN: begin
          if (res_ready) begin
            if (idx_q == IDX_LAST) begin
              idx_d   = '0;
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              idx_d = idx_q + IDX_WL'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Controller registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  for (genvar g = 0; g < NUM_CAND; g++) begin : g_cand
    sq_err_acc #(
      .DATA_WL (DATA_WL),
      .ACC_WL  (ACC_WL)
    ) u_acc (
      .clk      (clk),
      .rstn     (rstn),
      .clear    (clear),
      .in_valid (feed),
      .data_in  (data_in[g]),
      .data_ref (data_ref),
      .acc      (acc_all[g])
    );
  end

  // Result mux: mean of the selected candidate, zero outside DRAIN.
  always_comb begin
    res_data = '0;
    if (state_q == DRAIN) begin
      res_data = acc_all[idx_q] >> LOG2_NS;
    end
  end

  assign res_idx   = idx_q;
  assign res_valid = (state_q == DRAIN);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mse_batch_collector.sv
// Bench for mse_batch_collector: two instances (64-bit and 24-bit
// accumulators) share stimulus; results are checked against a mean-of-
// squared-errors model built from the recorded sample stream.
module tb_mse_batch_collector;
  import mse_pkg::*;

  localparam int NC = 2;
  localparam int NS = 4;
  localparam int SK = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0, abort = 1'b0, in_valid = 1'b0, res_ready = 1'b1;
  logic [11:0] data_in [NC];
  logic [11:0] data_ref;
  logic [63:0] res_data;
  logic [0:0]  res_idx;
  logic        res_valid, busy, done;
  logic [2:0]  dbg_state;
  logic [23:0] res_data_s;
  logic [0:0]  res_idx_s;
  logic        res_valid_s, busy_s, done_s;
  logic [2:0]  dbg_state_s;

  mse_batch_collector #(.NUM_CAND(NC), .DATA_WL(12), .ACC_WL(64), .NUM_SAMPLES(NS), .SKIP(SK)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort), .in_valid(in_valid),
    .data_in(data_in), .data_ref(data_ref), .res_data(res_data), .res_idx(res_idx),
    .res_valid(res_valid), .res_ready(res_ready), .busy(busy), .done(done), .dbg_state(dbg_state));

  mse_batch_collector #(.NUM_CAND(NC), .DATA_WL(12), .ACC_WL(24), .NUM_SAMPLES(NS), .SKIP(SK)) dut_s (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort), .in_valid(in_valid),
    .data_in(data_in), .data_ref(data_ref), .res_data(res_data_s), .res_idx(res_idx_s),
    .res_valid(res_valid_s), .res_ready(res_ready), .busy(busy_s), .done(done_s), .dbg_state(dbg_state_s));

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad = 0;
  int stim_ref[$], stim_d0[$], stim_d1[$];
  logic [63:0] exp_q[$];
  logic [23:0] exp_s_q[$];
  logic [63:0] got_q[$];
  logic [23:0] got_s_q[$];
  int          got_idx_q[$];
  logic obs_busy_start, obs_done_h1, obs_busy_h1, obs_done_h2;
  int   obs_lat, obs_flush, obs_stab_err, obs_stall_done;

  // Reference: mean over the NS samples that follow the SK discarded ones,
  // with the 24-bit variant clipped at its full scale before dividing.
  function automatic void build_expected();
    longint unsigned s;
    longint unsigned mx;
    longint d;
    mx = (64'd1 << 24) - 64'd1;
    exp_q.delete();
    exp_s_q.delete();
    for (int k = 0; k < NC; k++) begin
      s = 0;
      for (int i = SK; i < SK + NS; i++) begin
        d = longint'((k == 0) ? stim_d0[i] : stim_d1[i]) - longint'(stim_ref[i]);
        s = s + longint'(d * d);
      end
      exp_q.push_back(64'(s / NS));
      exp_s_q.push_back(24'(((s > mx) ? mx : s) / NS));
    end
  endfunction

  function automatic void clear_stim();
    stim_ref.delete(); stim_d0.delete(); stim_d1.delete();
  endfunction

  function automatic void add_sample(input int r, input int d0, input int d1);
    stim_ref.push_back(r); stim_d0.push_back(d0); stim_d1.push_back(d1);
  endfunction

  function automatic int rnd12();
    return int'($urandom_range(4095)) - 2048;
  endfunction

  // ---------------- drivers ----------------
  task automatic drive_sample(input int i);
    data_ref   = 12'(stim_ref[i]);
    data_in[0] = 12'(stim_d0[i]);
    data_in[1] = 12'(stim_d1[i]);
  endtask

  // Start a batch and present SK+NS valid samples with gap idle cycles
  // (random junk data) between them. Returns at the negedge after the
  // edge that captured the last sample.
  task automatic feed_batch(input int gap);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    obs_busy_start = busy;
    for (int i = 0; i < SK + NS; i++) begin
      in_valid = 1'b1;
      drive_sample(i);
      @(negedge clk);
      if (i < SK + NS - 1) begin
        for (int g = 0; g < gap; g++) begin
          in_valid   = 1'b0;
          data_ref   = 12'($urandom);
          data_in[0] = 12'($urandom);
          data_in[1] = 12'($urandom);
          @(negedge clk);
        end
      end
    end
    in_valid = 1'b0;
  endtask

  // Observe the flush latency, optionally stall the consumer, then record
  // every result handshake and the done/busy behaviour around the last one.
  task automatic collect(input int stall);
    int          cyc;
    logic [63:0] v_data;
    logic [0:0]  v_idx;
    got_q.delete(); got_s_q.delete(); got_idx_q.delete();
    obs_lat = 0; obs_flush = 0; obs_stab_err = 0; obs_stall_done = 0;
    while (res_valid !== 1'b1 && obs_lat < 20) begin
      if (dbg_state == 3'(FLUSH)) obs_flush++;
      @(negedge clk);
      obs_lat++;
    end
    if (stall > 0 && res_valid === 1'b1) begin
      res_ready = 1'b0;
      v_data = res_data;
      v_idx  = res_idx;
      for (int c = 0; c < stall; c++) begin
        @(negedge clk);
        if (res_valid !== 1'b1 || res_data !== v_data || res_idx !== v_idx) obs_stab_err++;
        if (done !== 1'b0) obs_stall_done++;
      end
      res_ready = 1'b1;
    end
    cyc = 0;
    while (got_q.size() < NC && cyc < 50) begin
      if (res_valid === 1'b1 && res_ready === 1'b1) begin
        got_q.push_back(res_data);
        got_s_q.push_back(res_data_s);
        got_idx_q.push_back(int'(res_idx));
      end
      @(negedge clk);
      cyc++;
    end
    obs_done_h1 = done;
    obs_busy_h1 = busy;
    @(negedge clk);
    obs_done_h2 = done;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #12;
    total++; if (res_data !== 64'd0 || res_idx !== 1'b0) begin bad++; $display("FAIL reset_res data=%0d idx=%0d want 0/0", res_data, res_idx); end
    total++; if (res_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_flags valid=%b busy=%b done=%b want 000", res_valid, busy, done); end
    total++; if (dbg_state !== 3'(IDLE)) begin bad++; $display("FAIL reset_state got=%0d want=%0d", dbg_state, 3'(IDLE)); end
    total++; if ({res_data_s, res_idx_s, res_valid_s, busy_s, done_s, dbg_state_s} !== '0) begin bad++; $display("FAIL reset_sat_inst data=%0d valid=%b busy=%b want all 0", res_data_s, res_valid_s, busy_s); end
    @(negedge clk); rstn = 1'b1;
  endtask

  task automatic test_equal();
    int r;
    clear_stim();
    for (int i = 0; i < SK + NS; i++) begin r = rnd12(); add_sample(r, r, r); end
    build_expected();
    feed_batch(0);
    collect(0);
    total++; if (obs_busy_start !== 1'b1) begin bad++; $display("FAIL eq_busy_start got=%b want=1", obs_busy_start); end
    for (int k = 0; k < NC; k++) begin
      total++; if (k >= got_q.size() || got_q[k] !== exp_q[k] || got_idx_q[k] != k) begin bad++; $display("FAIL eq_res%0d got=%0d want=%0d (got %0d results)", k, (k < got_q.size()) ? got_q[k] : 64'hx, exp_q[k], got_q.size()); end
    end
    total++; if (obs_done_h1 !== 1'b1 || obs_busy_h1 !== 1'b0 || obs_done_h2 !== 1'b0) begin bad++; $display("FAIL eq_done done=%b busy=%b done_next=%b want 1/0/0", obs_done_h1, obs_busy_h1, obs_done_h2); end
  endtask

  task automatic test_offsets();
    int r;
    clear_stim();
    for (int i = 0; i < SK + NS; i++) begin
      r = int'($urandom_range(4000)) - 2000;
      if (i < SK) add_sample(r, (r > 0) ? r - 1800 : r + 1800, (r > 0) ? -2048 : 2047);
      else        add_sample(r, r + 3, r - 5);
    end
    build_expected();
    feed_batch(0);
    collect(0);
    total++; if (obs_lat != 2 || obs_flush != 2) begin bad++; $display("FAIL offs_latency lat=%0d flush=%0d want 2/2", obs_lat, obs_flush); end
    for (int k = 0; k < NC; k++) begin
      total++; if (k >= got_q.size() || got_q[k] !== exp_q[k] || got_idx_q[k] != k) begin bad++; $display("FAIL offs_res%0d got=%0d want=%0d", k, (k < got_q.size()) ? got_q[k] : 64'hx, exp_q[k]); end
    end
    total++; if (obs_done_h1 !== 1'b1 || obs_busy_h1 !== 1'b0) begin bad++; $display("FAIL offs_done done=%b busy=%b want 1/0", obs_done_h1, obs_busy_h1); end
  endtask

  task automatic test_saturation();
    clear_stim();
    for (int i = 0; i < SK + NS; i++) add_sample(2047, -2048, rnd12());
    build_expected();
    feed_batch(0);
    collect(0);
    for (int k = 0; k < NC; k++) begin
      total++; if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin bad++; $display("FAIL sat_wide%0d got=%0d want=%0d", k, (k < got_q.size()) ? got_q[k] : 64'hx, exp_q[k]); end
      total++; if (k >= got_s_q.size() || got_s_q[k] !== exp_s_q[k]) begin bad++; $display("FAIL sat_narrow%0d got=%0d want=%0d", k, (k < got_s_q.size()) ? got_s_q[k] : 24'hx, exp_s_q[k]); end
    end
  endtask

  task automatic test_gaps();
    int r;
    clear_stim();
    for (int i = 0; i < SK + NS; i++) begin
      r = int'($urandom_range(4000)) - 2000;
      if (i < SK) add_sample(r, rnd12(), rnd12());
      else        add_sample(r, r + 3, r - 5);
    end
    build_expected();
    feed_batch(2);
    collect(0);
    total++; if (obs_lat != 2 || obs_flush != 2) begin bad++; $display("FAIL gap_latency lat=%0d flush=%0d want 2/2", obs_lat, obs_flush); end
    for (int k = 0; k < NC; k++) begin
      total++; if (k >= got_q.size() || got_q[k] !== exp_q[k] || got_idx_q[k] != k) begin bad++; $display("FAIL gap_res%0d got=%0d want=%0d", k, (k < got_q.size()) ? got_q[k] : 64'hx, exp_q[k]); end
    end
  endtask

  task automatic test_ready_stall();
    clear_stim();
    for (int i = 0; i < SK + NS; i++) add_sample(rnd12(), rnd12(), rnd12());
    build_expected();
    feed_batch(int'($urandom_range(1)));
    collect(10);
    total++; if (obs_stab_err != 0) begin bad++; $display("FAIL stall_stable unstable_cycles=%0d want 0", obs_stab_err); end
    total++; if (obs_stall_done != 0) begin bad++; $display("FAIL stall_no_done done_cycles=%0d want 0", obs_stall_done); end
    for (int k = 0; k < NC; k++) begin
      total++; if (k >= got_q.size() || got_q[k] !== exp_q[k] || got_idx_q[k] != k) begin bad++; $display("FAIL stall_res%0d got=%0d want=%0d", k, (k < got_q.size()) ? got_q[k] : 64'hx, exp_q[k]); end
    end
    total++; if (obs_done_h1 !== 1'b1 || obs_done_h2 !== 1'b0) begin bad++; $display("FAIL stall_done done=%b next=%b want 1/0", obs_done_h1, obs_done_h2); end
  endtask

  task automatic test_abort();
    int seen;
    clear_stim();
    for (int i = 0; i < SK + NS; i++) add_sample(rnd12(), rnd12(), rnd12());
    build_expected();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < SK + 2; i++) begin in_valid = 1'b1; drive_sample(i); @(negedge clk); end
    in_valid = 1'b0;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    total++; if (busy !== 1'b1 || dbg_state !== 3'(ACCUM)) begin bad++; $display("FAIL abort_start_busy busy=%b state=%0d want 1/%0d", busy, dbg_state, 3'(ACCUM)); end
    abort = 1'b1; start = 1'b1;
    @(negedge clk); abort = 1'b0; start = 1'b0;
    total++; if (busy !== 1'b0 || res_valid !== 1'b0 || dbg_state !== 3'(IDLE)) begin bad++; $display("FAIL abort_idle busy=%b valid=%b state=%0d want 0/0/0", busy, res_valid, dbg_state); end
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (res_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) seen++;
      @(negedge clk);
    end
    total++; if (seen != 0) begin bad++; $display("FAIL abort_quiet active_cycles=%0d want 0", seen); end
    feed_batch(0);
    collect(0);
    for (int k = 0; k < NC; k++) begin
      total++; if (k >= got_q.size() || got_q[k] !== exp_q[k] || got_idx_q[k] != k) begin bad++; $display("FAIL abort_clean_res%0d got=%0d want=%0d", k, (k < got_q.size()) ? got_q[k] : 64'hx, exp_q[k]); end
    end
    total++; if (obs_done_h1 !== 1'b1) begin bad++; $display("FAIL abort_clean_done got=%b want=1", obs_done_h1); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    clear_stim();
    for (int i = 0; i < SK + NS; i++) add_sample(rnd12(), rnd12(), rnd12());
    feed_batch(0);
    res_ready = 1'b0;
    cyc = 0;
    while (res_valid !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
    total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL rmid_reach_drain valid=%b want=1", res_valid); end
    #2 rstn = 1'b0;
    #1;
    total++; if (res_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || res_idx !== 1'b0 || res_data !== 64'd0) begin bad++; $display("FAIL rmid_async valid=%b busy=%b done=%b idx=%0d data=%0d want all 0", res_valid, busy, done, res_idx, res_data); end
    @(negedge clk); rstn = 1'b1; res_ready = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    data_ref   = '0;
    data_in[0] = '0;
    data_in[1] = '0;
    test_reset();
    test_equal();
    test_offsets();
    test_saturation();
    test_gaps();
    test_ready_stall();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

endmodule
